// File: rtl/riscv_types_pkg.sv
// Shared RV32 execute-stage types: divider operation codes and divider FSM states.
package riscv_types;

    localparam int DIV_XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_FIN  = 2'b10
    } div_state_t;

endpackage

// File: rtl/exe_div_unit_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left and trial-subtract the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // The shifted remainder can reach 2*divisor-1, so one extra bit is kept for the subtract.
    assign shifted_s = {rem, quo[XLEN-1]};
    assign diff_s    = shifted_s - {1'b0, divisor};

    // Commit the difference only when it did not borrow.
    always_comb begin
        rem_next = shifted_s[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (diff_s[XLEN] == 1'b0) begin
            rem_next = diff_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/n_bit_reg.sv
// Generic N-bit register with write enable and asynchronous active-low clear.
module n_bit_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wen,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Storage: cleared by reset, loaded when wen is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= {N{1'b0}};
        end else if (wen) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/exe_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional macro DIV_FAST_ZERO_EN: divide-by-zero skips the iterations and finishes at once.
module exe_div_unit
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    div_state_t      state_r;
    div_state_t      state_s;
    logic [CW-1:0]   count_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] dvd_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            div_zero_r;
    logic            rem_sel_r;
    logic            done_r;

    div_op_t         op_in_s;
    logic            signed_op_s;
    logic            accept_s;
    logic            step_s;
    logic            fin_s;
    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic [XLEN-1:0] rem_step_s;
    logic [XLEN-1:0] quo_step_s;
    logic [XLEN-1:0] q_fix_s;
    logic [XLEN-1:0] r_fix_s;
    logic [XLEN-1:0] result_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign op_in_s     = div_op_t'(op);
    assign signed_op_s = ~op[0];
    assign abs_a_s     = cond_neg(dividend, signed_op_s & dividend[XLEN-1]);
    assign abs_b_s     = cond_neg(divisor,  signed_op_s & divisor[XLEN-1]);

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and per-state strobes; flush always wins back to IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        fin_s    = 1'b0;
        case (state_r)
            DIV_IDLE: begin
                if (start && !flush) begin
                    accept_s = 1'b1;
`ifdef DIV_FAST_ZERO_EN
                    if (divisor == {XLEN{1'b0}}) begin
                        state_s = DIV_FIN;
                    end else begin
                        state_s = DIV_RUN;
                    end
`else
                    state_s = DIV_RUN;
`endif
                end else begin
                    state_s = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    state_s = DIV_IDLE;
                end else if (count_r == {CW{1'b0}}) begin
                    step_s  = 1'b1;
                    state_s = DIV_FIN;
                end else begin
                    step_s  = 1'b1;
                    state_s = DIV_RUN;
                end
            end
            DIV_FIN: begin
                if (flush) begin
                    fin_s = 1'b0;
                end else begin
                    fin_s = 1'b1;
                end
                state_s = DIV_IDLE;
            end
            default: begin
                state_s = DIV_IDLE;
            end
        endcase
    end

    // Operand capture at acceptance, then one restoring step per edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r    <= {CW{1'b0}};
            rem_r      <= {XLEN{1'b0}};
            quo_r      <= {XLEN{1'b0}};
            dvs_r      <= {XLEN{1'b0}};
            dvd_r      <= {XLEN{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            rem_sel_r  <= 1'b0;
        end else if (accept_s) begin
            count_r    <= CW'(XLEN - 1);
            rem_r      <= {XLEN{1'b0}};
            quo_r      <= abs_a_s;
            dvs_r      <= abs_b_s;
            dvd_r      <= dividend;
            neg_q_r    <= (op_in_s == DIV_S) & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r_r    <= (op_in_s == REM_S) & dividend[XLEN-1];
            div_zero_r <= (divisor == {XLEN{1'b0}});
            rem_sel_r  <= op[1];
        end else if (step_s) begin
            count_r    <= count_r - {{(CW-1){1'b0}}, 1'b1};
            rem_r      <= rem_step_s;
            quo_r      <= quo_step_s;
        end else begin
            count_r    <= count_r;
            rem_r      <= rem_r;
            quo_r      <= quo_r;
        end
    end

    // Divide-by-zero forces all-ones quotient and hands back the untouched dividend.
    always_comb begin
        q_fix_s  = cond_neg(quo_r, neg_q_r);
        r_fix_s  = cond_neg(rem_r, neg_r_r);
        if (div_zero_r) begin
            q_fix_s = {XLEN{1'b1}};
            r_fix_s = dvd_r;
        end else begin
            q_fix_s = cond_neg(quo_r, neg_q_r);
            r_fix_s = cond_neg(rem_r, neg_r_r);
        end
        if (rem_sel_r) begin
            result_s = r_fix_s;
        end else begin
            result_s = q_fix_s;
        end
    end

    // Completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= fin_s;
        end
    end

    n_bit_reg #(.N(XLEN)) u_result (
        .clk     (clk),
        .reset_n (reset_n),
        .wen     (fin_s),
        .d       (result_s),
        .q       (result)
    );

    assign busy = (state_r != DIV_IDLE);
    assign done = done_r;

endmodule

// File: tb/tb_exe_div_unit.sv
// Randomized self-checking bench for exe_div_unit against an arithmetic reference model.
module tb_exe_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_exp;

    exe_div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension division semantics.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (o[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return o[1] ? r : q;
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_FAST_ZERO_EN
        return (b == 32'd0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1 in an idle or done cycle; returns at posedge+1 in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke_busy);
        logic [31:0] exp;
        int          lat;
        int          busy_cnt;
        int          lat_exp;
        exp      = ref_div(o, a, b);
        lat_exp  = exp_latency(b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        check_val("done_low_after_accept", {31'd0, done}, 32'd0);
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start = (poke_busy && k == 5) ? 1'b1 : 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check_val("latency", 32'(lat), 32'(lat_exp));
        check_val("busy_cycles", 32'(busy_cnt), 32'(lat_exp));
        check_val("busy_low_in_done", {31'd0, busy}, 32'd0);
        check_val("result", result, exp);
        if (lat != 0) last_exp = exp;
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_errors = 0;
        last_exp = 32'd0;
        reset_n  = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'd0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #1;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_result", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases, issued back-to-back.
        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'd5, 32'd0, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0);
        run_op(2'b01, 32'hDEAD_BEEF, 32'd3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
        end

        // Flush at iteration 10: no done, result keeps its prior value.
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_val("flush_busy", {31'd0, busy}, 32'd0);
        check_val("flush_done", {31'd0, done}, 32'd0);
        check_val("flush_result", result, last_exp);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check_val("flush_no_done", 32'(dones), 32'd0);

        // Start together with flush in IDLE is ignored.
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check_val("flush_start_ignored", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        start    = 1'b1;
        op       = 2'b00;
        dividend = 32'd12345;
        divisor  = 32'd17;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("mid_reset_busy", {31'd0, busy}, 32'd0);
        check_val("mid_reset_done", {31'd0, done}, 32'd0);
        check_val("mid_reset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'b00, 32'd12345, 32'd17, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
